pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Single pipeline stage register with valid/ready handshake and a bubble-safe control field.
// Define PIPE_STAGE_SKID_EN to add a skid register, which makes ready_o a registered flag.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        occ_o
);

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = main_valid && ready_i;

  // A bubble must never leak control bits such as regWrite or memToWrite downstream.
  assign valid_o = main_valid;
  assign ctrl_o  = main_valid ? main_ctrl : '0;
  assign data_o  = main_data;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic              skid_empty;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // skid_empty is its own flop so ready_o has no combinational path from ready_i.
  assign ready_o = skid_empty;
  assign occ_o   = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_empty <= 1'b1;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      skid_empty <= 1'b1;
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_ctrl  <= skid_ctrl;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_empty <= 1'b1;
      end else if (in_xfer) begin
        main_ctrl <= ctrl_i;
        main_data <= data_i;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      if (main_valid) begin
        skid_valid <= 1'b1;
        skid_empty <= 1'b0;
        skid_ctrl  <= ctrl_i;
        skid_data  <= data_i;
      end else begin
        main_valid <= 1'b1;
        main_ctrl  <= ctrl_i;
        main_data  <= data_i;
      end
    end
  end
`else
  assign ready_o = ready_i || !main_valid;
  assign occ_o   = {1'b0, main_valid};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_data  <= '0;
    end else if (flush_i) begin
      main_valid <= 1'b0;
    end else if (in_xfer) begin
      main_valid <= 1'b1;
      main_ctrl  <= ctrl_i;
      main_data  <= data_i;
    end else if (out_xfer) begin
      main_valid <= 1'b0;
    end
  end
`endif

endmodule
